// File: rtl/jt03_wrq_pkg.sv
// rtl/jt03_wrq_pkg.sv - shared state, entry layout and constants for the jt03 write sequencer
package jt03_wrq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_GAP  = 3'd2,
      ST_DATA = 3'd3,
      ST_POLL = 3'd4
   } wrq_state_t;

   localparam int BUSY_BIT = 7;

   typedef struct packed {
      logic [7:0] rg;
      logic [7:0] val;
   } wrq_entry_t;

   function automatic logic [15:0] pack_entry(input logic [7:0] r, input logic [7:0] v);
      wrq_entry_t e;
      e.rg  = r;
      e.val = v;
      return e;
   endfunction

endpackage

// File: rtl/jt03_wrq_fifo.sv
// rtl/jt03_wrq_fifo.sv - DEPTH x 16 register-pair FIFO with occupancy counter
module jt03_wrq_fifo
   import jt03_wrq_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [15:0]              push_data,
   input  logic                     pop,
   output logic [15:0]              pop_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   logic [15:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          w_push;
   logic          w_pop;

   // Gated here as well so a caller can never overrun or underrun the storage.
   assign w_push   = push & (r_level != LVL_FULL);
   assign w_pop    = pop & (r_level != '0);
   assign full     = (r_level == LVL_FULL);
   assign level    = r_level;
   assign pop_data = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/jt03_wrq.sv
// rtl/jt03_wrq.sv - replays buffered (reg, value) writes on the jt03 bus with busy polling
module jt03_wrq
   import jt03_wrq_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int SETUP        = 2,
   parameter int BUSY_TIMEOUT = 255
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cen,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [7:0]               wr_reg,
   input  logic [7:0]               wr_val,
   output logic [7:0]               ym_din,
   output logic                     ym_addr,
   output logic                     ym_cs_n,
   output logic                     ym_wr_n,
   input  logic [7:0]               ym_dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     idle,
   output logic                     timeout_err,
   input  logic                     clr_err
);

   localparam logic [7:0] GAP_LAST  = 8'(SETUP - 1);
   localparam logic [7:0] BUSY_LAST = 8'(BUSY_TIMEOUT - 1);

   wrq_state_t              r_state;
   logic [7:0]              r_din;
   logic                    r_addr;
   logic                    r_cs_n;
   logic                    r_wr_n;
   logic [7:0]              r_val;
   logic [7:0]              r_gap_cnt;
   logic [7:0]              r_busy_cnt;
   logic                    r_poll_setup;
   logic                    r_timeout_err;

   logic [15:0]             w_head_raw;
   wrq_entry_t              w_head;
   logic [$clog2(DEPTH):0]  w_level;
   logic                    w_full;
   logic                    w_pop;
   logic                    w_sample;
   logic                    w_busy;
   logic                    w_timeout_hit;
   logic                    w_unused;

   jt03_wrq_fifo #(
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (wr_valid),
      .push_data (pack_entry(wr_reg, wr_val)),
      .pop       (w_pop),
      .pop_data  (w_head_raw),
      .level     (w_level),
      .full      (w_full)
   );

   assign w_head        = wrq_entry_t'(w_head_raw);
   assign w_pop         = cen && (r_state == ST_IDLE) && (w_level != '0);
   // The first POLL cycle only sets up the status read; samples start after it.
   assign w_sample      = (r_state == ST_POLL) && !r_poll_setup;
   assign w_busy        = ym_dout[BUSY_BIT];
   assign w_timeout_hit = cen && w_sample && w_busy && (r_busy_cnt == BUSY_LAST);
   assign w_unused      = ^ym_dout[6:0];

   assign wr_ready    = ~w_full;
   assign level       = w_level;
   assign idle        = (r_state == ST_IDLE) && (w_level == '0);
   assign ym_din      = r_din;
   assign ym_addr     = r_addr;
   assign ym_cs_n     = r_cs_n;
   assign ym_wr_n     = r_wr_n;
   assign timeout_err = r_timeout_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_din        <= '0;
         r_addr       <= 1'b0;
         r_cs_n       <= 1'b1;
         r_wr_n       <= 1'b1;
         r_val        <= '0;
         r_gap_cnt    <= '0;
         r_busy_cnt   <= '0;
         r_poll_setup <= 1'b0;
      end else if (cen) begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_state <= ST_ADDR;
                  r_cs_n  <= 1'b0;
                  r_wr_n  <= 1'b0;
                  r_addr  <= 1'b0;
                  r_din   <= w_head.rg;
                  r_val   <= w_head.val;
               end
            end
            ST_ADDR: begin
               r_state   <= ST_GAP;
               r_cs_n    <= 1'b1;
               r_wr_n    <= 1'b1;
               r_gap_cnt <= '0;
            end
            ST_GAP: begin
               if (r_gap_cnt == GAP_LAST) begin
                  r_state <= ST_DATA;
                  r_cs_n  <= 1'b0;
                  r_wr_n  <= 1'b0;
                  r_addr  <= 1'b1;
                  r_din   <= r_val;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               r_state      <= ST_POLL;
               r_cs_n       <= 1'b0;
               r_wr_n       <= 1'b1;
               r_addr       <= 1'b0;
               r_busy_cnt   <= '0;
               r_poll_setup <= 1'b1;
            end
            ST_POLL: begin
               if (r_poll_setup) begin
                  r_poll_setup <= 1'b0;
               end else if (!w_busy || (r_busy_cnt == BUSY_LAST)) begin
                  // A stuck busy flag drops the entry; the host only sees timeout_err.
                  r_state <= ST_IDLE;
                  r_cs_n  <= 1'b1;
                  r_wr_n  <= 1'b1;
               end else begin
                  r_busy_cnt <= r_busy_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cs_n  <= 1'b1;
               r_wr_n  <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timeout_err <= 1'b0;
      end else if (w_timeout_hit) begin
         r_timeout_err <= 1'b1;
      end else if (clr_err) begin
         r_timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jt03_wrq.sv
// tb/tb_jt03_wrq.sv - scoreboard bench for the jt03 register-write sequencer
`timescale 1ns/1ps
module tb_jt03_wrq;

   localparam int SETUP = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cen = 1'b0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [7:0] wr_reg = 8'h00;
   logic [7:0] wr_val = 8'h00;
   logic [7:0] ym_din;
   logic       ym_addr;
   logic       ym_cs_n;
   logic       ym_wr_n;
   logic [7:0] ym_dout = 8'h00;
   logic [3:0] level;
   logic       idle;
   logic       timeout_err;
   logic       clr_err = 1'b0;

   int total = 0;
   int bad = 0;
   int cen_div = 1;
   int cen_cnt = 0;
   int cyc = 0;
   int n_stb = 0;
   int b2b_last = -1;
   bit b2b_on = 1'b0;

   logic [15:0] exp_q[$];
   logic [15:0] m_e;
   logic        m_prev = 1'b0;
   logic        m_stb;
   logic        m_kind = 1'b0;
   logic [7:0]  m_reg = 8'h00;
   int          m_start = 0;
   int          m_addr_end = 0;
   int          s0;

   jt03_wrq #(
      .DEPTH        (8),
      .SETUP        (SETUP),
      .BUSY_TIMEOUT (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cen         (cen),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_reg      (wr_reg),
      .wr_val      (wr_val),
      .ym_din      (ym_din),
      .ym_addr     (ym_addr),
      .ym_cs_n     (ym_cs_n),
      .ym_wr_n     (ym_wr_n),
      .ym_dout     (ym_dout),
      .level       (level),
      .idle        (idle),
      .timeout_err (timeout_err),
      .clr_err     (clr_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (cen_div <= 0) begin
         cen = 1'b0;
      end else begin
         cen = (cen_cnt == 0);
         cen_cnt = (cen_cnt + 1) % cen_div;
      end
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Bus monitor: strobe widths, GAP length, back-to-back spacing and write order.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_prev = 1'b0;
      end else begin
         m_stb = !ym_cs_n && !ym_wr_n;
         if (m_stb && !m_prev) begin
            n_stb++;
            m_start = cyc;
            m_kind  = ym_addr;
            if (!ym_addr) begin
               if (b2b_on && b2b_last >= 0) chk_eq("b2b_spacing", cyc - b2b_last, 7);
               b2b_last = cyc;
               m_reg = ym_din;
               if (exp_q.size() > 0) chk_eq("addr_din", ym_din, exp_q[0][15:8]);
            end else begin
               chk_eq("gap_width", cyc - m_addr_end, SETUP * cen_div);
               chk_eq("data_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  m_e = exp_q.pop_front();
                  chk_eq("data_reg", m_reg, m_e[15:8]);
                  chk_eq("data_val", ym_din, m_e[7:0]);
               end
            end
         end
         if (!m_stb && m_prev) begin
            chk_eq("strobe_width", cyc - m_start, cen_div);
            if (!m_kind) m_addr_end = cyc;
         end
         m_prev = m_stb;
      end
   end

   task automatic push(input logic [7:0] r, input logic [7:0] v);
      int n;
      n = 0;
      wr_valid = 1'b1;
      wr_reg = r;
      wr_val = v;
      while (!wr_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) chk_eq("push_ready_timeout", wr_ready, 1'b1);
      @(posedge clk);
      if (n < 200) exp_q.push_back({r, v});
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (!(idle && ym_cs_n) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk_eq(tag, idle, 1'b1);
      chk_eq({tag, "_queue_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst_wr_ready", wr_ready, 1'b1);
      chk_eq("rst_cs_n", ym_cs_n, 1'b1);
      chk_eq("rst_wr_n", ym_wr_n, 1'b1);
      chk_eq("rst_din", ym_din, 8'h00);
      chk_eq("rst_addr", ym_addr, 1'b0);
      chk_eq("rst_level", level, 4'd0);
      chk_eq("rst_idle", idle, 1'b1);
      chk_eq("rst_timeout", timeout_err, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // single write, cycle-exact
      push(8'h27, 8'h15);
      chk_eq("t1_level_after_push", level, 4'd1);
      chk_eq("t1_idle_after_push", idle, 1'b0);
      @(posedge clk); #1;
      chk_eq("t1_addr_cs_n", ym_cs_n, 1'b0);
      chk_eq("t1_addr_wr_n", ym_wr_n, 1'b0);
      chk_eq("t1_addr_din", ym_din, 8'h27);
      chk_eq("t1_addr_a0", ym_addr, 1'b0);
      chk_eq("t1_level_after_pop", level, 4'd0);
      repeat (3) @(posedge clk); #1;
      chk_eq("t1_data_wr_n", ym_wr_n, 1'b0);
      chk_eq("t1_data_din", ym_din, 8'h15);
      chk_eq("t1_data_a0", ym_addr, 1'b1);
      repeat (2) @(posedge clk); #1;
      chk_eq("t1_idle_edge6", idle, 1'b0);
      @(posedge clk); #1;
      chk_eq("t1_idle_edge7", idle, 1'b1);

      // fill while frozen, then DEPTH+1 entries drain in order back-to-back
      cen_div = 0;
      repeat (2) @(posedge clk); #1;
      b2b_last = -1;
      b2b_on = 1'b1;
      for (int i = 0; i < 8; i++) push(8'h30 + 8'(i), 8'hA0 + 8'(i));
      chk_eq("t2_level_full", level, 4'd8);
      chk_eq("t2_ready_full", wr_ready, 1'b0);
      wr_valid = 1'b1;
      wr_reg = 8'h38;
      wr_val = 8'hA8;
      repeat (3) @(posedge clk); #1;
      chk_eq("t2_full_rejects", level, 4'd8);
      cen_div = 1;
      push(8'h38, 8'hA8);
      chk_eq("t2_ninth_accepted", level, 4'd8);
      wait_idle("t2_drain");
      b2b_on = 1'b0;

      // busy for 3 samples then clear
      ym_dout = 8'h80;
      push(8'h40, 8'h41);
      push(8'h42, 8'h43);
      repeat (8) @(posedge clk); #1;
      chk_eq("t3_still_poll_cs", ym_cs_n, 1'b0);
      chk_eq("t3_still_poll_wr", ym_wr_n, 1'b1);
      ym_dout = 8'h00;
      @(posedge clk); #1;
      chk_eq("t3_poll_end_cs", ym_cs_n, 1'b1);
      chk_eq("t3_next_pending", level, 4'd1);
      @(posedge clk); #1;
      chk_eq("t3_next_addr_cs", ym_cs_n, 1'b0);
      chk_eq("t3_next_addr_din", ym_din, 8'h42);
      wait_idle("t3_drain");
      chk_eq("t3_no_timeout", timeout_err, 1'b0);

      // busy stuck: timeout, next entry still issues, set beats clear
      ym_dout = 8'h80;
      push(8'h50, 8'h51);
      push(8'h52, 8'h53);
      repeat (8) @(posedge clk); #1;
      chk_eq("t4_before_timeout", timeout_err, 1'b0);
      @(posedge clk); #1;
      chk_eq("t4_timeout_set", timeout_err, 1'b1);
      chk_eq("t4_timeout_release", ym_cs_n, 1'b1);
      @(posedge clk); #1;
      chk_eq("t4_next_addr_din", ym_din, 8'h52);
      chk_eq("t4_next_addr_cs", ym_cs_n, 1'b0);
      @(posedge clk); #1;
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
      chk_eq("t4_clr_works", timeout_err, 1'b0);
      repeat (6) @(posedge clk); #1;
      chk_eq("t4_before_second", timeout_err, 1'b0);
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
      chk_eq("t4_set_beats_clr", timeout_err, 1'b1);
      ym_dout = 8'h00;
      wait_idle("t4_drain");
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
      chk_eq("t4_final_clr", timeout_err, 1'b0);

      // cen 1-of-4: widths and GAP scale, pushes land on non-cen cycles
      cen_div = 4;
      repeat (4) @(posedge clk); #1;
      push(8'h60, 8'h61);
      push(8'h62, 8'h63);
      push(8'h64, 8'h65);
      wait_idle("t5_drain");
      cen_div = 1;
      repeat (4) @(posedge clk); #1;

      // async reset during GAP
      push(8'h70, 8'h71);
      push(8'h72, 8'h73);
      @(posedge clk); #1;
      chk_eq("t6_in_gap_din", ym_din, 8'h70);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk_eq("t6_rst_cs_n", ym_cs_n, 1'b1);
      chk_eq("t6_rst_wr_n", ym_wr_n, 1'b1);
      chk_eq("t6_rst_din", ym_din, 8'h00);
      chk_eq("t6_rst_level", level, 4'd0);
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      s0 = n_stb;
      repeat (20) @(posedge clk); #1;
      chk_eq("t6_no_resume", n_stb - s0, 0);
      chk_eq("t6_idle", idle, 1'b1);
      chk_eq("t6_level", level, 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jt03_wrq.md
# jt03_wrq

Register-write sequencer for the YM2203 core (jt03). It buffers host (reg, value) pairs in a small FIFO and replays each one on the chip's two-port bus: address write, settle gap, data write, then a status-poll until the busy flag clears. It sits between the CPU/firmware side and jt03 so that hosts never handle busy-wait timing themselves. It owns jt03's din/addr/cs_n/wr_n and observes its dout.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of 2, ≥2.
- SETUP, 2: cen cycles between address and data strobes; ≥1.
- BUSY_TIMEOUT, 255: maximum busy samples per write; 1..255.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, shared with jt03.
- rst_n  in  1  asynchronous active-low reset.
- cen  in  1  clock enable, same signal fed to jt03; FSM advances only when cen=1.
- wr_valid  in  1  host offers a write.
- wr_ready  out  1  FIFO not full; reset value 1.
- wr_reg  in  8  register number.
- wr_val  in  8  register value.
- ym_din  out  8  to jt03 din; reset 0.
- ym_addr  out  1  to jt03 addr; reset 0.
- ym_cs_n  out  1  reset 1.
- ym_wr_n  out  1  reset 1.
- ym_dout  in  8  from jt03 dout; bit 7 = busy.
- level  out  $clog2(DEPTH)+1  FIFO occupancy; reset 0.
- idle  out  1  FIFO empty and FSM in IDLE; reset 1.
- timeout_err  out  1  sticky; reset 0.
- clr_err  in  1  clears timeout_err.

## Operation
- Push: wr_valid & wr_ready on any clk edge (cen-independent) writes {wr_reg, wr_val}. wr_ready = (level != DEPTH). Push while full is impossible by construction.
- Pop happens on the IDLE→ADDR transition. Simultaneous push and pop leave level unchanged.
- FSM (all transitions on clk edges with cen=1):
  - IDLE: bus released (cs_n=1, wr_n=1). Go to ADDR if level≠0.
  - ADDR: cs_n=0, wr_n=0, addr=0, din=reg. Go to GAP.
  - GAP: cs_n=1, wr_n=1. Stay SETUP cen cycles. Go to DATA.
  - DATA: cs_n=0, wr_n=0, addr=1, din=val. Go to POLL.
  - POLL: cs_n=0, wr_n=1, addr=0.
    - First cen cycle is read setup; no sample is taken.
    - Each later cen cycle samples ym_dout[7].
    - If the sample is 0, go to IDLE.
    - If BUSY_TIMEOUT consecutive samples read 1, set timeout_err and go to IDLE. The entry is dropped; there is no retry.
- All bus outputs are registered and change only on cen edges. Each strobe is held for exactly one cen period.
- timeout_err: set has priority over a clr_err in the same cycle. clr_err is cen-independent.
- The busy counter is 8 bits and is cleared when entering POLL.

## Timing
- Minimum per-entry cost: 5+SETUP cen cycles (IDLE 1, ADDR 1, GAP SETUP, DATA 1, POLL 2). With SETUP=2 and cen=1, back-to-back ADDR strobes are 7 clk apart.
- Latency from push into an empty FIFO to the ADDR strobe visible on the bus: push edge, then 1 cen cycle in IDLE, then ADDR at the next cen edge.
- level and wr_ready update on the clk edge after a push or pop.
- idle deasserts on the edge following the first push.
- rst_n low mid-operation: bus outputs return to their reset values immediately (asynchronously), the FIFO is emptied, and the state goes to IDLE. After reset, no partial write is resumed.
- cen=0: the FSM, bus outputs and busy counter freeze; the FIFO still accepts pushes.

## Structure
- Package jt03_wrq_pkg:
  - state encoding (IDLE, ADDR, GAP, DATA, POLL, 3 bits);
  - BUSY_BIT=7 constant;
  - 16-bit entry layout {reg[15:8], val[7:0]}.
- Sub-module jt03_wrq_fifo:
  - synchronous push/pop, DEPTH×16 storage;
  - read and write pointers with wrap-around at DEPTH;
  - level counter;
  - async active-low clear.
- Top level holds the FSM, GAP/busy counters and output registers.

## Test plan
- Single write reg 0x27 val 0x15, cen=1, busy low → ADDR strobe (din=0x27, addr=0) then DATA strobe (din=0x15, addr=1) 3 clk later; idle=1 on the 7th edge.
- Push DEPTH+1 entries in consecutive cycles → wr_ready=0 at level=8. All 8 entries are written in FIFO order; the 9th is accepted once level drops.
- Hold ym_dout[7]=1 for 3 samples, then 0 → POLL lasts 5 cen cycles, no error, next entry starts.
- BUSY_TIMEOUT=4, busy stuck at 1 → timeout_err=1 after 4 samples; the next entry still issues. clr_err coincident with a new timeout leaves timeout_err=1.
- cen toggling 1-of-4 → strobe widths are exactly 4 clk and GAP spans SETUP×4 clk; pushes are accepted while cen=0.
- rst_n pulsed low during GAP → cs_n=1 and wr_n=1 in the same cycle, level=0, no DATA strobe follows.
